// File: rtl/axi_dma_pkg.sv
// Shared types and constants for the AXI stream-to-memory write DMA.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_dma_burst_calc.sv
// Burst sizer: beats = min(remaining, MAX_BURST_LEN, words left before the next 4 KB line).
// Latency: purely combinational.
// Backpressure: none; the caller registers the result when it starts a burst.
module axi_dma_burst_calc
  import axi_dma_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int LEN_WIDTH     = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int STRB_WIDTH    = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [CNT_WIDTH-1:0]  remaining,
  output logic [LEN_WIDTH:0]    beats,
  output logic [LEN_WIDTH-1:0]  awlen
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  // Wide enough for the count, the cap and the 13-bit distance to the 4 KB line.
  localparam int CW   = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  logic [CW-1:0] rem_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] bound_w;
  logic [CW-1:0] lim;
  logic          unused_addr;

  assign rem_w       = CW'(remaining);
  assign max_w       = CW'(MAX_BURST_LEN);
  // Upper address bits never influence the burst size.
  assign unused_addr = ^addr;

  generate
    if (ADDR_WIDTH >= 12) begin : g_4k
      logic [12:0] to_bound;
      // 4096 - offset needs 13 bits when the offset is zero.
      assign to_bound = 13'(BOUNDARY_4K) - {1'b0, addr[11:0]};
      assign bound_w  = CW'(to_bound >> SIZE);
    end else begin : g_no4k
      // Address space smaller than one 4 KB page: no boundary to respect.
      assign bound_w = max_w;
    end
  endgenerate

  // Take the smallest of the three limits.
  always_comb begin
    lim = (rem_w < max_w) ? rem_w : max_w;
    if (bound_w < lim) lim = bound_w;
  end

  assign beats = (LEN_WIDTH + 1)'(lim);
  assign awlen = LEN_WIDTH'(lim - CW'(1));

endmodule

// File: rtl/axi_dma_wr.sv
// Stream-to-AXI4 write master: splits (address, word count) commands into INCR bursts, one outstanding.
// Latency: awvalid 1 cycle after command accept; done_o 1 cycle after the last B handshake.
// Backpressure: s_ready_o is axi_wready_i gated by the DATA state (no buffering); cmd_ready_o low while busy.
// Optional feature macro AXI_DMA_WR_ERR_EN: sticky err_o on any non-OKAY bresp.
module axi_dma_wr
  import axi_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int LEN_WIDTH     = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int AXI_ID        = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [CNT_WIDTH-1:0]  cmd_len_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ID_WIDTH-1:0]   axi_awid_o,
  output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
  output logic [LEN_WIDTH-1:0]  axi_awlen_o,
  output logic [2:0]            axi_awsize_o,
  output logic [1:0]            axi_awburst_o,
  output logic [1:0]            axi_awlock_o,
  output logic [3:0]            axi_awcache_o,
  output logic [2:0]            axi_awprot_o,
  output logic [3:0]            axi_awqos_o,
  output logic                  axi_awvalid_o,
  input  logic                  axi_awready_i,
  output logic [DATA_WIDTH-1:0] axi_wdata_o,
  output logic [STRB_WIDTH-1:0] axi_wstrb_o,
  output logic                  axi_wlast_o,
  output logic                  axi_wvalid_o,
  input  logic                  axi_wready_i,
  input  logic [ID_WIDTH-1:0]   axi_bid_i,
  input  logic [1:0]            axi_bresp_i,
  input  logic                  axi_bvalid_i,
  output logic                  axi_bready_o
);

  localparam int SIZE = $clog2(STRB_WIDTH);

  state_t                state_q, state_d;
  logic                  cmd_ready_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  awlen_q;
  logic [LEN_WIDTH:0]    beats_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;

  logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic [CNT_WIDTH-1:0]  calc_rem;
  logic [LEN_WIDTH:0]    calc_beats;
  logic [LEN_WIDTH-1:0]  calc_awlen;
  logic                  cmd_fire, aw_fire, w_fire, b_fire, wlast;

  assign cmd_addr_aligned = cmd_addr_i & ({ADDR_WIDTH{1'b1}} << SIZE);

  assign cmd_fire = cmd_valid_i & cmd_ready_q;
  assign aw_fire  = (state_q == ADDR) & axi_awready_i;
  assign w_fire   = (state_q == DATA) & s_valid_i & axi_wready_i;
  assign b_fire   = (state_q == RESP) & axi_bvalid_i;
  assign wlast    = (beat_cnt_q == awlen_q);

  // The first burst is sized from the live command; later bursts from the running address/count.
  assign calc_addr = (state_q == IDLE) ? cmd_addr_aligned : addr_q;
  assign calc_rem  = (state_q == IDLE) ? cmd_len_i        : rem_q;

  axi_dma_burst_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .STRB_WIDTH    (STRB_WIDTH)
  ) u_burst_calc (
    .addr      (calc_addr),
    .remaining (calc_rem),
    .beats     (calc_beats),
    .awlen     (calc_awlen)
  );

  // Next-state logic for the one-burst-at-a-time sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_fire && (cmd_len_i != '0)) state_d = ADDR;
      ADDR: if (aw_fire) state_d = DATA;
      DATA: if (w_fire && wlast) state_d = RESP;
      RESP: if (b_fire) state_d = (rem_q != '0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Command/burst datapath: running address and count, AW payload, beat counter, handshake flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
    end else begin
      cmd_ready_q <= (state_d == IDLE);
      done_q      <= (cmd_fire && (cmd_len_i == '0)) || (b_fire && (rem_q == '0));
      if (cmd_fire) begin
        addr_q <= cmd_addr_aligned;
        rem_q  <= cmd_len_i;
      end
      // AW payload is captured on entry to ADDR and held until awready.
      if ((state_d == ADDR) && (state_q != ADDR)) begin
        awaddr_q <= calc_addr;
        awlen_q  <= calc_awlen;
        beats_q  <= calc_beats;
      end
      if (aw_fire) begin
        addr_q     <= addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
        rem_q      <= rem_q - CNT_WIDTH'(beats_q);
        beat_cnt_q <= '0;
      end
      if (w_fire) beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

`ifdef AXI_DMA_WR_ERR_EN
  logic err_q;
  logic unused_b;

  assign unused_b = ^axi_bid_i;

  // Sticky error: set by any non-OKAY response, cleared when the next command is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                err_q <= 1'b0;
    else if (cmd_fire)                        err_q <= 1'b0;
    else if (b_fire && (axi_bresp_i != RESP_OKAY)) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_b;

  assign unused_b = ^{axi_bid_i, axi_bresp_i};
  assign err_o    = 1'b0;
`endif

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

  assign axi_awid_o    = ID_WIDTH'(AXI_ID);
  assign axi_awaddr_o  = awaddr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = 3'(SIZE);
  assign axi_awburst_o = BURST_INCR;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'h0;
  assign axi_awprot_o  = 3'h0;
  assign axi_awqos_o   = 4'h0;
  assign axi_awvalid_o = (state_q == ADDR);

  assign axi_wdata_o   = s_data_i;
  assign axi_wstrb_o   = '1;
  assign axi_wlast_o   = wlast;
  assign axi_wvalid_o  = s_valid_i & (state_q == DATA);
  assign s_ready_o     = axi_wready_i & (state_q == DATA);

  assign axi_bready_o  = (state_q == RESP);

endmodule

// File: doc/axi_dma_wr.md
# axi_dma_wr

Stream-to-AXI4 write master that sits directly upstream of `axi_ram` and drives its AW/W/B channels. It accepts a command (start address, word count) plus a valid/ready data stream, and splits the transfer into INCR bursts. Each burst is capped at `MAX_BURST_LEN` beats and never crosses a 4 KB boundary. Exactly one burst is outstanding at a time.

## Interface
- `DATA_WIDTH`, 32: AXI data width in bits; must equal the slave's width.
- `ADDR_WIDTH`, 16: AXI address width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: wstrb width; must be a power of two.
- `ID_WIDTH`, 8: AXI ID width.
- `LEN_WIDTH`, 8: awlen width.
- `MAX_BURST_LEN`, 16: beats per burst, range 1..2**`LEN_WIDTH`.
- `CNT_WIDTH`, 16: width of the command word count.
- `AXI_ID`, 0: constant driven on awid.
- `clk_i` input 1: clock. The block has one clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `cmd_addr_i` input `ADDR_WIDTH`: start byte address. The low `$clog2(STRB_WIDTH)` bits are ignored (forced 0).
- `cmd_len_i` input `CNT_WIDTH`: number of words to write; 0 is legal.
- `cmd_valid_i` input 1, `cmd_ready_o` output 1: command handshake.
- `s_data_i` input `DATA_WIDTH`, `s_valid_i` input 1, `s_ready_o` output 1: data stream.
- `busy_o` output 1: command in progress.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: sticky write-error flag (see Configuration).
- `axi_awid_o` `ID_WIDTH`, `axi_awaddr_o` `ADDR_WIDTH`, `axi_awlen_o` `LEN_WIDTH`, `axi_awsize_o` 3, `axi_awburst_o` 2, `axi_awlock_o` 2, `axi_awcache_o` 4, `axi_awprot_o` 3, `axi_awqos_o` 4, `axi_awvalid_o` 1: outputs. `axi_awready_i` 1: input.
- `axi_wdata_o` `DATA_WIDTH`, `axi_wstrb_o` `STRB_WIDTH`, `axi_wlast_o` 1, `axi_wvalid_o` 1: outputs. `axi_wready_i` 1: input.
- `axi_bid_i` `ID_WIDTH`, `axi_bresp_i` 2, `axi_bvalid_i` 1: inputs. `axi_bready_o` 1: output.

## Operation
- States and transitions:
  - IDLE: `cmd_ready_o`=1. On command accept, latch address and remaining count. If count is 0, pulse `done_o` next cycle and stay in IDLE; otherwise go to ADDR.
  - ADDR: `axi_awvalid_o`=1. On awready, go to DATA.
  - DATA: stream beats. After the beat with wlast is accepted, go to RESP.
  - RESP: `axi_bready_o`=1. On bvalid, if remaining > 0 go to ADDR, else pulse `done_o` and go to IDLE.
- Burst beat count = min(remaining, `MAX_BURST_LEN`, words to the next 4 KB boundary).
  - Words to boundary = (4096 − addr[11:0]) >> `$clog2(STRB_WIDTH)`. If `ADDR_WIDTH` < 12, the boundary term is ignored.
  - awlen = beats − 1.
- Fixed AW fields:
  - awsize = `$clog2(STRB_WIDTH)`.
  - awburst = 2'b01 (INCR).
  - awlock, awcache, awprot, awqos = 0.
  - awid = `AXI_ID`.
- W channel:
  - wdata = `s_data_i`; wstrb = all ones.
  - wvalid = `s_valid_i` & (state==DATA).
  - `s_ready_o` = `axi_wready_i` & (state==DATA). This is a combinational pass-through; no data buffering.
  - wlast = (beat counter == awlen).
- Next burst address = previous address + beats × `STRB_WIDTH`, modulo 2**`ADDR_WIDTH` (wraps silently).
- `busy_o` = (state != IDLE).
- `axi_bid_i` is ignored.

## Timing
- Reset values:
  - `cmd_ready_o`, `axi_awvalid_o`, `axi_bready_o`, `done_o`, `busy_o`, `err_o` = 0.
  - `axi_wvalid_o` = 0 and `s_ready_o` = 0, because the state is IDLE.
  - AW payload registers = 0.
- `cmd_ready_o` rises the first cycle after `rst_i` deasserts.
- Command accepted at cycle N: awvalid asserts at N+1.
- AW accepted at cycle M: the first W beat can transfer at M+1.
- wlast beat accepted: bready asserts the next cycle.
- B accepted at cycle K: next awvalid or `done_o` at K+1.
- `done_o` is high for exactly one cycle. `cmd_ready_o` returns to 1 in the same cycle as `done_o`.
- awvalid and the AW payload stay stable until awready; this is AXI-compliant.
- `rst_i` asserted mid-burst aborts immediately: all valids drop next cycle and the remaining count is discarded. No recovery of the slave state is attempted.

## Configuration
- Macro: `AXI_DMA_WR_ERR_EN`.
- Defined:
  - Any bresp ≠ 2'b00 sets `err_o`.
  - `err_o` clears on the next command accept.
  - The transfer continues to completion.
- Undefined: `err_o` tied to 0 and `axi_bresp_i` unused.

## Structure
- Shared package `axi_dma_pkg`:
  - state enum (IDLE, ADDR, DATA, RESP);
  - constants BURST_INCR = 2'b01, RESP_OKAY = 2'b00, BOUNDARY_4K = 4096.
- One sub-module, `axi_dma_burst_calc`: combinational; computes beats and awlen from address, remaining count and `MAX_BURST_LEN`.

## Test plan
1. cmd addr 0x0010, len 1 → one AW with addr 0x0010, awlen 0, awsize 2; one W beat with wlast=1; `done_o` pulses after B.
2. cmd addr 0x0000, len 40, `MAX_BURST_LEN`=16 → AWs at 0x0000/0x0040/0x0080 with awlen 15/15/7; data read back from `axi_ram` matches the stream.
3. cmd addr 0x0FF8, len 8 → AW 0x0FF8 awlen 1, then AW 0x1000 awlen 5; no burst crosses 4 KB.
4. Random `s_valid_i` gaps, `axi_wready_i` toggling, bvalid delayed 10 cycles → no lost or duplicated beats; awvalid stable while stalled.
5. cmd len 0 → no AXI activity; `done_o` pulse one cycle after accept. Then `rst_i` asserted during DATA of a 40-word command → all outputs at reset values next cycle; a new command works.
6. With `AXI_DMA_WR_ERR_EN`, bresp 2'b10 on the second of three bursts → `err_o`=1 until the next command accept; all three bursts complete.
